mvm_bn_res_post: RTL and testbench

//  Post-MVM epilogue stage: consumes Tout-lane accumulator bursts from the HBM MVM array and applies a
//  per-channel BN scale and bias, an optional residual add and optional ReLU, then saturates to DAT_DW.

---
 rtl/mvm_post_pkg.sv | 40 ++++
 rtl/mvm_post_lane.sv | 58 +++++
 rtl/mvm_bn_res_post.sv | 185 ++++++++++++++++++
 tb/tb_mvm_bn_res_post.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvm_post_pkg.sv
// Shared types and helpers for the post-MVM BN / residual / ReLU epilogue.
package mvm_post_pkg;

    localparam int ACC_DW = 32;
    localparam int DAT_DW = 16;
    localparam int BN_DW  = 16;
    localparam int PROD_W = ACC_DW + BN_DW;
    localparam int SUM_W  = ACC_DW + BN_DW + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    typedef logic signed [ACC_DW-1:0] acc_t;
    typedef logic signed [DAT_DW-1:0] dat_t;
    typedef logic signed [BN_DW-1:0]  bn_t;
    typedef logic signed [SUM_W-1:0]  sum_t;

    localparam sum_t DAT_MAX = {{(SUM_W-DAT_DW+1){1'b0}}, {(DAT_DW-1){1'b1}}};
    localparam sum_t DAT_MIN = {{(SUM_W-DAT_DW+1){1'b1}}, {(DAT_DW-1){1'b0}}};

    // Optional ReLU, then clamp the wide result into the signed output range.
    function automatic dat_t relu_sat(input sum_t y, input logic relu_en);
        dat_t r;
        if (relu_en && y[SUM_W-1]) begin
            r = '0;
        end else if (y > DAT_MAX) begin
            r = DAT_MAX[DAT_DW-1:0];
        end else if (y < DAT_MIN) begin
            r = DAT_MIN[DAT_DW-1:0];
        end else begin
            r = y[DAT_DW-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/mvm_post_lane.sv
// One output lane: S2 multiply and S3 shift/add/ReLU/saturate.
module mvm_post_lane
    import mvm_post_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       adv,
    input  acc_t       acc,
    input  bn_t        wt,
    input  bn_t        bias,
    input  dat_t       res,
    input  logic       res_en,
    input  logic       relu_en,
    input  logic [4:0] wt_sh,
    input  logic [4:0] bias_sh,
    input  logic [4:0] res_sh,
    input  logic [4:0] out_sh,
    output dat_t       y
);

    logic signed [PROD_W-1:0] p2;
    bn_t  bias2;
    dat_t res2;
    sum_t p_ext, b_ext, r_ext, r_term, s, y_full;

    // S2: signed product; bias and residual travel alongside it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p2    <= '0;
            bias2 <= '0;
            res2  <= '0;
        end else if (adv) begin
            p2    <= PROD_W'(acc) * PROD_W'(wt);
            bias2 <= bias;
            res2  <= res;
        end
    end

    // S3 combinational: align terms, sum, floor-shift to output scale
    always_comb begin
        p_ext  = SUM_W'(p2);
        b_ext  = SUM_W'(bias2);
        r_ext  = SUM_W'(res2);
        r_term = res_en ? (r_ext <<< res_sh) : '0;
        s      = (p_ext >>> wt_sh) + (b_ext <<< bias_sh) + r_term;
        y_full = s >>> out_sh;
    end

    // S3 register: ReLU and saturation into the lane output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y <= '0;
        end else if (adv) begin
            y <= relu_sat(y_full, relu_en);
        end
    end

endmodule

// File: rtl/mvm_bn_res_post.sv
// Post-MVM epilogue: per-channel-group BN, optional residual add and ReLU,
// saturation. Stream order is channel group outer, pixel inner.
// Handshakes: a beat transfers on a cycle where valid and ready are both
// high; valid never depends on ready; acc and res are always consumed together.
module mvm_bn_res_post
    import mvm_post_pkg::*;
#(
    parameter int TOUT    = 32,
    parameter int MAX_CHG = 64,
    parameter int PIX_W   = 20
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [6:0]                cfg_chg,
    input  logic [PIX_W-1:0]          cfg_pix,
    input  logic                      cfg_relu_en,
    input  logic                      cfg_res_en,
    input  logic [4:0]                cfg_wt_sh,
    input  logic [4:0]                cfg_bias_sh,
    input  logic [4:0]                cfg_res_sh,
    input  logic [4:0]                cfg_out_sh,
    input  logic                      bn_valid,
    output logic                      bn_ready,
    input  logic [TOUT*2*BN_DW-1:0]   bn_data,
    input  logic                      acc_valid,
    output logic                      acc_ready,
    input  logic [TOUT*ACC_DW-1:0]    acc_data,
    input  logic                      res_valid,
    output logic                      res_ready,
    input  logic [TOUT*DAT_DW-1:0]    res_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [TOUT*DAT_DW-1:0]    out_data,
    output logic                      busy,
    output logic                      done,
    output logic [1:0]                dbg_state
);

    localparam int CHG_AW = $clog2(MAX_CHG);
    localparam int BN_LW  = 2 * BN_DW;

    state_t state, state_nx;

    logic [6:0]       cfg_chg_q;
    logic [PIX_W-1:0] cfg_pix_q;
    logic             relu_en_q, res_en_q;
    logic [4:0]       wt_sh_q, bias_sh_q, res_sh_q, out_sh_q;

    logic [6:0]       k_cnt, chg_cnt;
    logic [PIX_W-1:0] pix_cnt;

    logic adv, in_ok, fire, bn_xfer, load_last, last_in, pix_wrap;
    logic v1, v2, v3;

    logic [TOUT*ACC_DW-1:0] acc1;
    logic [TOUT*DAT_DW-1:0] res1;
    logic [TOUT*BN_LW-1:0]  bn1;
    logic [TOUT*BN_LW-1:0]  bn_ram [MAX_CHG];

    // Handshake and control decode
    always_comb begin
        adv       = !v3 || out_ready;
        in_ok     = (state == RUN) && adv;
        acc_ready = in_ok && (res_valid || !res_en_q);
        res_ready = in_ok && acc_valid && res_en_q;
        fire      = acc_valid && acc_ready;
        bn_ready  = (state == LOAD);
        bn_xfer   = bn_valid && bn_ready;
        load_last = (k_cnt == cfg_chg_q - 7'd1);
        pix_wrap  = (pix_cnt == cfg_pix_q - PIX_W'(1));
        last_in   = (chg_cnt == cfg_chg_q - 7'd1) && pix_wrap;
        out_valid = v3;
        busy      = (state != IDLE);
        done      = (state == DRAIN) && v3 && out_ready && !v1 && !v2;
        dbg_state = state;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // FSM next state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start)                state_nx = LOAD;
            LOAD:    if (bn_xfer && load_last) state_nx = RUN;
            RUN:     if (fire && last_in)      state_nx = DRAIN;
            DRAIN:   if (done)                 state_nx = IDLE;
            default:                           state_nx = IDLE;
        endcase
    end

    // Job configuration, captured once per start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_chg_q <= '0;
            cfg_pix_q <= '0;
            relu_en_q <= 1'b0;
            res_en_q  <= 1'b0;
            wt_sh_q   <= '0;
            bias_sh_q <= '0;
            res_sh_q  <= '0;
            out_sh_q  <= '0;
        end else if (state == IDLE && start) begin
            cfg_chg_q <= cfg_chg;
            cfg_pix_q <= cfg_pix;
            relu_en_q <= cfg_relu_en;
            res_en_q  <= cfg_res_en;
            wt_sh_q   <= cfg_wt_sh;
            bias_sh_q <= cfg_bias_sh;
            res_sh_q  <= cfg_res_sh;
            out_sh_q  <= cfg_out_sh;
        end
    end

    // BN load index and stream position counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_cnt   <= '0;
            chg_cnt <= '0;
            pix_cnt <= '0;
        end else if (state == IDLE && start) begin
            k_cnt   <= '0;
            chg_cnt <= '0;
            pix_cnt <= '0;
        end else begin
            if (bn_xfer) k_cnt <= load_last ? 7'd0 : k_cnt + 7'd1;
            if (fire) begin
                if (pix_wrap) begin
                    pix_cnt <= '0;
                    chg_cnt <= chg_cnt + 7'd1;
                end else begin
                    pix_cnt <= pix_cnt + PIX_W'(1);
                end
            end
        end
    end

    // BN parameter buffer: written during LOAD, read synchronously in S1
    always_ff @(posedge clk) begin
        if (bn_xfer) bn_ram[k_cnt[CHG_AW-1:0]] <= bn_data;
        if (adv)     bn1 <= bn_ram[chg_cnt[CHG_AW-1:0]];
    end

    // S1 register and pipeline valids; the whole pipe stalls together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
            acc1 <= '0;
            res1 <= '0;
        end else if (adv) begin
            v1   <= fire;
            v2   <= v1;
            v3   <= v2;
            acc1 <= acc_data;
            res1 <= res_data;
        end
    end

    for (genvar i = 0; i < TOUT; i++) begin : g_lane
        mvm_post_lane u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .adv     (adv),
            .acc     (acc1[i*ACC_DW +: ACC_DW]),
            .wt      (bn1[i*BN_LW +: BN_DW]),
            .bias    (bn1[i*BN_LW+BN_DW +: BN_DW]),
            .res     (res1[i*DAT_DW +: DAT_DW]),
            .res_en  (res_en_q),
            .relu_en (relu_en_q),
            .wt_sh   (wt_sh_q),
            .bias_sh (bias_sh_q),
            .res_sh  (res_sh_q),
            .out_sh  (out_sh_q),
            .y       (out_data[i*DAT_DW +: DAT_DW])
        );
    end

endmodule

// File: tb/tb_mvm_bn_res_post.sv
// Bench for mvm_bn_res_post: directed and random jobs against a plain
// arithmetic reference, checked through an expected-output queue.
module tb_mvm_bn_res_post;

    localparam int TOUT = 32;
    localparam int ACC_DW = 32;
    localparam int DAT_DW = 16;
    localparam int BN_DW = 16;
    localparam int PIX_W = 20;
    localparam int OW = TOUT*DAT_DW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [6:0] cfg_chg = '0;
    logic [PIX_W-1:0] cfg_pix = '0;
    logic cfg_relu_en = 1'b0, cfg_res_en = 1'b0;
    logic [4:0] cfg_wt_sh = '0, cfg_bias_sh = '0, cfg_res_sh = '0, cfg_out_sh = '0;
    logic bn_valid = 1'b0;
    logic bn_ready;
    logic [TOUT*2*BN_DW-1:0] bn_data = '0;
    logic acc_valid = 1'b0;
    logic acc_ready;
    logic [TOUT*ACC_DW-1:0] acc_data = '0;
    logic res_valid = 1'b0;
    logic res_ready;
    logic [OW-1:0] res_data = '0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic [OW-1:0] out_data;
    logic busy, done;
    logic [1:0] dbg_state;

    mvm_bn_res_post dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_chg(cfg_chg), .cfg_pix(cfg_pix),
        .cfg_relu_en(cfg_relu_en), .cfg_res_en(cfg_res_en),
        .cfg_wt_sh(cfg_wt_sh), .cfg_bias_sh(cfg_bias_sh),
        .cfg_res_sh(cfg_res_sh), .cfg_out_sh(cfg_out_sh),
        .bn_valid(bn_valid), .bn_ready(bn_ready), .bn_data(bn_data),
        .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [OW-1:0] exp_q[$];
    bit            last_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int out_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int fire_cyc = 0;
    logic [OW-1:0] last_out = '0;
    logic [OW-1:0] hold_data = '0;
    bit hold_pend = 0;

    // stimulus knobs
    logic signed [BN_DW-1:0] bn_wt [64][TOUT];
    logic signed [BN_DW-1:0] bn_bias [64][TOUT];
    int acc_mode = 0;
    int acc_const = 0;
    int res_const = 0;
    bit res_rand = 0;
    bit rdy_rand = 0;
    bit res_gaps = 0;
    bit extra_start = 0;

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: one lane computed with wide integer arithmetic.
    function automatic logic [DAT_DW-1:0] ref_lane(input longint acc, input longint wt,
        input longint bias, input longint res, input bit ren, input bit relu,
        input int wsh, input int bsh, input int rsh, input int osh);
        longint s, y;
        s = ((acc * wt) >>> wsh) + (bias <<< bsh) + (ren ? (res <<< rsh) : 64'sd0);
        y = s >>> osh;
        if (relu && y < 0) y = 0;
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        return y[DAT_DW-1:0];
    endfunction

    task automatic set_group(input int g, input int wt, input int bias);
        for (int i = 0; i < TOUT; i++) begin
            bn_wt[g][i] = 16'(wt);
            bn_bias[g][i] = 16'(bias);
        end
    endtask

    // ---------------- sink-side ready driver ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [OW-1:0] e;
        bit l;
        if (!rst_n) begin
            hold_pend = 0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", OW'(out_valid), OW'(1));
                check("hold_data", out_data, hold_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("out_expected", OW'(0), OW'(1));
                end else begin
                    e = exp_q.pop_front();
                    l = last_q.pop_front();
                    check("out_data", out_data, e);
                    check("done_on_last", OW'(done), OW'(l));
                end
                out_cnt++;
                last_out = out_data;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end else if (done) begin
                check("done_without_xfer", OW'(done), OW'(0));
                done_cnt++;
            end
            hold_pend = out_valid && !out_ready;
            hold_data = out_data;
        end
    end

    // ---------------- job driver ----------------
    task automatic run_job(input int n_chg, input int n_pix, input bit relu, input bit ren,
        input int wsh, input int bsh, input int rsh, input int osh, input int abort_after);
        logic [TOUT*ACC_DW-1:0] a_vec;
        logic [OW-1:0] r_vec, e_vec;
        logic [TOUT*2*BN_DW-1:0] b_vec;
        logic signed [ACC_DW-1:0] a_l;
        logic signed [DAT_DW-1:0] r_l;
        bit got, r_ok, b_rdy, need_new;
        int fired, t, d0, g, fcyc;

        d0 = done_cnt;
        cfg_chg = 7'(n_chg);
        cfg_pix = PIX_W'(n_pix);
        cfg_relu_en = relu;
        cfg_res_en = ren;
        cfg_wt_sh = 5'(wsh);
        cfg_bias_sh = 5'(bsh);
        cfg_res_sh = 5'(rsh);
        cfg_out_sh = 5'(osh);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", OW'(busy), OW'(1));

        for (int k = 0; k < n_chg; k++) begin
            for (int i = 0; i < TOUT; i++) begin
                b_vec[i*2*BN_DW +: BN_DW] = bn_wt[k][i];
                b_vec[i*2*BN_DW+BN_DW +: BN_DW] = bn_bias[k][i];
            end
            bn_valid = 1'b1;
            bn_data = b_vec;
            t = 0;
            do begin
                @(negedge clk);
                got = bn_ready;
                @(posedge clk); #1;
                t++;
            end while (!got && t < 100);
            check("bn_accept", OW'(got), OW'(1));
        end
        bn_valid = 1'b0;

        fired = 0;
        t = 0;
        need_new = 1;
        while (fired < n_chg * n_pix) begin
            if (need_new) begin
                g = fired / n_pix;
                for (int i = 0; i < TOUT; i++) begin
                    case (acc_mode)
                        0: a_l = $urandom;
                        1: a_l = acc_const;
                        default: a_l = i;
                    endcase
                    r_l = res_rand ? 16'($urandom) : 16'(res_const);
                    a_vec[i*ACC_DW +: ACC_DW] = a_l;
                    r_vec[i*DAT_DW +: DAT_DW] = r_l;
                    e_vec[i*DAT_DW +: DAT_DW] = ref_lane(a_l, bn_wt[g][i], bn_bias[g][i], r_l,
                                                         ren, relu, wsh, bsh, rsh, osh);
                end
                need_new = 0;
            end
            acc_valid = 1'b1;
            acc_data = a_vec;
            res_data = r_vec;
            res_valid = ren ? (!res_gaps || $urandom_range(0, 2) != 0) : 1'($urandom_range(0, 1));
            bn_valid = extra_start;
            start = extra_start && fired == 1;
            @(negedge clk);
            got = acc_ready;
            r_ok = res_ready;
            b_rdy = bn_ready;
            fcyc = cyc;
            @(posedge clk); #1;
            if (got) begin
                check("res_ready_pair", OW'(r_ok), OW'(ren));
                check("bn_ready_in_run", OW'(b_rdy), OW'(0));
                exp_q.push_back(e_vec);
                last_q.push_back(fired == n_chg * n_pix - 1);
                fire_cyc = fcyc;
                fired++;
                need_new = 1;
                if (fired == abort_after) begin
                    acc_valid = 1'b0;
                    res_valid = 1'b0;
                    bn_valid = 1'b0;
                    start = 1'b0;
                    rst_n = 1'b0;
                    #1;
                    check("abort_out_valid", OW'(out_valid), OW'(0));
                    check("abort_out_data", out_data, OW'(0));
                    check("abort_busy", OW'(busy), OW'(0));
                    check("abort_acc_ready", OW'(acc_ready), OW'(0));
                    exp_q.delete();
                    last_q.delete();
                    repeat (3) @(posedge clk);
                    #1;
                    rst_n = 1'b1;
                    check("abort_no_done", OW'(done_cnt - d0), OW'(0));
                    return;
                end
            end else begin
                t++;
                if (t > 2000) begin
                    check("acc_accept_timeout", OW'(0), OW'(1));
                    break;
                end
            end
        end
        acc_valid = 1'b0;
        res_valid = 1'b0;
        bn_valid = 1'b0;
        start = 1'b0;

        t = 0;
        while (done_cnt == d0 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("job_done_count", OW'(done_cnt - d0), OW'(1));
        check("sb_empty", OW'(exp_q.size()), OW'(0));
        check("busy_after_done", OW'(busy), OW'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int oc0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", OW'(out_valid), OW'(0));
        check("rst_out_data", out_data, OW'(0));
        check("rst_busy", OW'(busy), OW'(0));
        check("rst_done", OW'(done), OW'(0));
        check("rst_acc_ready", OW'(acc_ready), OW'(0));
        check("rst_res_ready", OW'(res_ready), OW'(0));
        check("rst_bn_ready", OW'(bn_ready), OW'(0));
        check("rst_state", OW'(dbg_state), OW'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: basic BN + residual, latency to done
        set_group(0, 8, 5);
        acc_mode = 1; acc_const = 100; res_rand = 0; res_const = -20;
        run_job(1, 1, 0, 1, 3, 0, 0, 0, -1);
        check("t1_lane0", OW'(last_out[15:0]), OW'(85));
        check("t1_latency", OW'(done_cyc - fire_cyc), OW'(3));

        // 2: ReLU on and off
        set_group(0, 1, 5);
        acc_const = -50;
        run_job(1, 1, 1, 0, 0, 0, 0, 0, -1);
        check("t2_relu", OW'(last_out[15:0]), OW'(0));
        run_job(1, 1, 0, 0, 0, 0, 0, 0, -1);
        check("t2_norelu", OW'(last_out[15:0]), OW'(16'hFFD3));

        // 3: saturation both ways
        set_group(0, 1, 0);
        acc_const = 40000;
        run_job(1, 1, 0, 0, 0, 0, 0, 0, -1);
        check("t3_sat_hi", OW'(last_out[15:0]), OW'(16'h7FFF));
        acc_const = -40000;
        run_job(1, 1, 0, 0, 0, 0, 0, 0, -1);
        check("t3_sat_lo", OW'(last_out[15:0]), OW'(16'h8000));

        // 4: three groups with distinct weights, acc = lane index
        set_group(0, 1, 0);
        set_group(1, 2, 0);
        set_group(2, 3, 0);
        acc_mode = 2;
        oc0 = out_cnt;
        run_job(3, 4, 0, 0, 0, 0, 0, 0, -1);
        check("t4_beats", OW'(out_cnt - oc0), OW'(12));
        check("t4_lane31", OW'(last_out[31*16 +: 16]), OW'(93));

        // 5: random data, back-pressure and residual gaps
        acc_mode = 0; res_rand = 1; rdy_rand = 1; res_gaps = 1; extra_start = 1;
        for (int j = 0; j < 6; j++) begin
            for (int g = 0; g < 64; g++)
                for (int i = 0; i < TOUT; i++) begin
                    bn_wt[g][i] = 16'($urandom);
                    bn_bias[g][i] = 16'($urandom);
                end
            if (j == 5)
                run_job($urandom_range(1, 8), $urandom_range(1, 10), 1'($urandom_range(0, 1)), 1,
                        $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                        $urandom_range(0, 31), -1);
            else
                run_job($urandom_range(1, 8), $urandom_range(1, 10), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), $urandom_range(8, 20), $urandom_range(0, 10),
                        $urandom_range(0, 4), $urandom_range(0, 4), -1);
        end

        // 6: reset mid-stream, then a full job with reloaded BN
        rdy_rand = 0; extra_start = 0;
        run_job(2, 8, 0, 1, 12, 4, 2, 1, 5);
        run_job(2, 8, 0, 1, 12, 4, 2, 1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
